// File: rtl/seq_pkg.sv
// Shared types for the instruction sequencer: FSM state encoding, instruction
// field positions and the default watchdog limit.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ISSUE,
    S_RELEASE,
    S_DONE
  } state_t;

  localparam int INST_EXEC_BIT = 31;
  localparam int SRC0_LSB      = 0;
  localparam int SRC0_W        = 5;
  localparam int SRC1_LSB      = 5;
  localparam int SRC1_W        = 5;
  localparam int DST_LSB       = 10;
  localparam int DST_W         = 5;
  localparam int INMODE_LSB    = 15;
  localparam int INMODE_W      = 5;
  localparam int OPMODE_LSB    = 20;
  localparam int OPMODE_W      = 7;
  localparam int ALUMODE_LSB   = 27;
  localparam int ALUMODE_W     = 4;

  localparam int SEQ_TIMEOUT   = 64;

  function automatic logic inst_is_exec(input logic [31:0] inst);
    return inst[INST_EXEC_BIT];
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Load/count/expire counter bounding how long the sequencer waits in ISSUE.
// expired is high once TIMEOUT counted cycles have been seen since load.
module seq_watchdog
  import seq_pkg::*;
#(
  parameter int TIMEOUT = SEQ_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // expired is combinational on cnt so the ISSUE cycle that reaches the limit acts on it
  assign expired = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || load) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/inst_sequencer.sv
// Fetches inst_count instructions from the instruction BRAM and issues them to
// the controller one at a time. Define SEQ_WATCHDOG_EN to bound the ISSUE wait.
module inst_sequencer
  import seq_pkg::*;
#(
  parameter int AW      = 10,
  parameter int DW      = 32,
  parameter int TIMEOUT = SEQ_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          stop,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] inst_count,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [AW-1:0] issued_cnt,
  output logic [AW-1:0] imem_addr,
  output logic          imem_en,
  input  logic [DW-1:0] imem_dout,
  output logic          ctrl_en,
  output logic [DW-1:0] ctrl_inst,
  input  logic          ctrl_valid
);

  state_t        state;
  logic [AW-1:0] base_q;
  logic [AW-1:0] count_q;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nxt;
  logic          stop_q;
  logic          last;

  assign idx_nxt = idx + AW'(1);
  // a stop arriving in the RELEASE cycle itself still ends the run here
  assign last    = (idx_nxt == count_q) || stop_q || stop;

`ifdef SEQ_WATCHDOG_EN
  logic wd_expired;

  seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .load    (state == S_WAIT),
    .count   (state == S_ISSUE),
    .expired (wd_expired)
  );
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      imem_en    <= 1'b0;
      ctrl_en    <= 1'b0;
      issued_cnt <= '0;
      imem_addr  <= '0;
      ctrl_inst  <= '0;
      base_q     <= '0;
      count_q    <= '0;
      idx        <= '0;
      stop_q     <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      error      <= 1'b0;
`endif
    end else begin
      if (state != S_IDLE && stop) begin
        stop_q <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            count_q    <= inst_count;
            idx        <= '0;
            issued_cnt <= '0;
            stop_q     <= 1'b0;
            busy       <= 1'b1;
`ifdef SEQ_WATCHDOG_EN
            error      <= 1'b0;
`endif
            if (inst_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state     <= S_FETCH;
              imem_en   <= 1'b1;
              imem_addr <= base_addr;
            end
          end
        end
        S_FETCH: begin
          imem_en <= 1'b0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          ctrl_inst <= imem_dout;
          ctrl_en   <= 1'b1;
          state     <= S_ISSUE;
        end
        S_ISSUE: begin
          if (ctrl_valid) begin
            ctrl_en <= 1'b0;
            state   <= S_RELEASE;
`ifdef SEQ_WATCHDOG_EN
          end else if (wd_expired) begin
            error   <= 1'b1;
            ctrl_en <= 1'b0;
            state   <= S_RELEASE;
`endif
          end
        end
        S_RELEASE: begin
          idx <= idx_nxt;
          // error can only be set here by this run's watchdog, so the timed-out instruction is not counted
          if (!error) begin
            issued_cnt <= issued_cnt + AW'(1);
          end
          if (last || error) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state     <= S_FETCH;
            imem_en   <= 1'b1;
            imem_addr <= base_q + idx_nxt;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inst_sequencer.sv
// Table-driven bench for inst_sequencer with a BRAM model and a controller
// model whose valid latency is 1 cycle for NOPs and Delay+3 for exec ones.
module tb_inst_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [9:0]  base_addr;
  logic [9:0]  inst_count;
  logic        busy;
  logic        done;
  logic        error;
  logic [9:0]  issued_cnt;
  logic [9:0]  imem_addr;
  logic        imem_en;
  logic [31:0] imem_dout;
  logic        ctrl_en;
  logic [31:0] ctrl_inst;
  logic        ctrl_valid;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [1024];
  int          delay = 0;
  bit          hold  = 1'b0;
  int          ccnt;
  int          lat;

  always #5 clk = ~clk;

  inst_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
    .base_addr  (base_addr),
    .inst_count (inst_count),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .issued_cnt (issued_cnt),
    .imem_addr  (imem_addr),
    .imem_en    (imem_en),
    .imem_dout  (imem_dout),
    .ctrl_en    (ctrl_en),
    .ctrl_inst  (ctrl_inst),
    .ctrl_valid (ctrl_valid)
  );

  always_ff @(posedge clk) begin
    if (imem_en) imem_dout <= mem[imem_addr];
  end

  always_ff @(posedge clk) begin
    if (rst || !ctrl_en) ccnt <= 0;
    else                 ccnt <= ccnt + 1;
  end

  assign lat        = ctrl_inst[31] ? delay + 3 : 1;
  assign ctrl_valid = ctrl_en && !hold && (ccnt == lat);

  typedef struct {
    int          base;
    int          count;
    logic [31:0] inst;
    int          dly;
    int          stop_issue;
    bit          restart;
    bit          stop_with_start;
    int          exp_done;
    int          exp_issued;
    int          exp_en_n;
    int          exp_en_first;
    int          exp_en_last;
    int          exp_a_first;
    int          exp_a_last;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int   en_n, en_first, en_last, fetch_n, done_at, a_first, a_last;
    bit   inst_ok, prev_en;
    for (int i = 0; i < 1024; i++) mem[i] = v.inst;
    delay = v.dly;
    @(posedge clk); #1;
    base_addr  = 10'(v.base);
    inst_count = 10'(v.count);
    start      = 1'b1;
    stop       = v.stop_with_start;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    en_n = 0; en_first = -1; en_last = -1; fetch_n = 0; done_at = -1;
    a_first = -1; a_last = -1; inst_ok = 1'b1; prev_en = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (imem_en) begin
        if (fetch_n == 0) a_first = int'(imem_addr);
        a_last = int'(imem_addr);
        fetch_n++;
      end
      if (ctrl_en && !prev_en) begin
        en_n++;
        if (en_n == 1) en_first = k;
        en_last = k;
        if (en_n == v.stop_issue) stop = 1'b1;
        if (en_n == 1 && v.restart) begin
          start      = 1'b1;
          inst_count = 10'd0;
          base_addr  = 10'd500;
        end
      end
      if (ctrl_en && ctrl_inst != v.inst) inst_ok = 1'b0;
      prev_en = ctrl_en;
      if (done) begin
        done_at = k;
        chk($sformatf("v%0d error", id), int'(error), 0);
        break;
      end
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
    end
    chk($sformatf("v%0d done_cycle", id), done_at, v.exp_done);
    chk($sformatf("v%0d en_count", id), en_n, v.exp_en_n);
    chk($sformatf("v%0d en_first", id), en_first, v.exp_en_first);
    chk($sformatf("v%0d en_last", id), en_last, v.exp_en_last);
    chk($sformatf("v%0d fetch_count", id), fetch_n, v.exp_en_n);
    chk($sformatf("v%0d addr_first", id), a_first, v.exp_a_first);
    chk($sformatf("v%0d addr_last", id), a_last, v.exp_a_last);
    chk($sformatf("v%0d ctrl_inst_held", id), int'(inst_ok), 1);
    @(posedge clk); #1;
    chk($sformatf("v%0d busy_after_done", id), int'(busy), 0);
    chk($sformatf("v%0d done_one_cycle", id), int'(done), 0);
    chk($sformatf("v%0d issued_cnt", id), int'(issued_cnt), v.exp_issued);
  endtask

  initial begin
    int n;
    vecs[0] = '{0,    3,  32'h0000_1234, 0, 0, 1'b0, 1'b0, 16, 3, 3, 3, 13, 0,    2};
    vecs[1] = '{5,    1,  32'h8000_0C21, 3, 0, 1'b0, 1'b0, 11, 1, 1, 3, 3,  5,    5};
    vecs[2] = '{1022, 4,  32'h0000_1234, 0, 0, 1'b0, 1'b0, 21, 4, 4, 3, 18, 1022, 1};
    vecs[3] = '{9,    0,  32'h0000_1234, 0, 0, 1'b0, 1'b0, 1,  0, 0, -1, -1, -1, -1};
    vecs[4] = '{100,  10, 32'h0000_1234, 0, 2, 1'b0, 1'b0, 11, 2, 2, 3, 8,  100,  101};
    vecs[5] = '{7,    2,  32'h8000_0C21, 0, 0, 1'b0, 1'b0, 15, 2, 2, 3, 10, 7,    8};
    vecs[6] = '{0,    2,  32'h0000_1234, 0, 0, 1'b1, 1'b0, 11, 2, 2, 3, 8,  0,    1};
    vecs[7] = '{3,    2,  32'h0000_1234, 0, 0, 1'b0, 1'b1, 11, 2, 2, 3, 8,  3,    4};

    rst = 1'b1; start = 1'b0; stop = 1'b0; base_addr = '0; inst_count = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset error", int'(error), 0);
    chk("reset imem_en", int'(imem_en), 0);
    chk("reset ctrl_en", int'(ctrl_en), 0);
    chk("reset issued_cnt", int'(issued_cnt), 0);
    chk("reset imem_addr", int'(imem_addr), 0);
    chk("reset ctrl_inst", int'(ctrl_inst), 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Stop in IDLE is ignored: nothing starts
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    chk("idle stop busy", int'(busy), 0);

    // Reset during the 2nd ISSUE of a fresh run
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_5678;
    delay = 0;
    @(posedge clk); #1;
    base_addr = 10'd100; inst_count = 10'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    for (int k = 0; k < 100 && n < 2; k++) begin
      if (ctrl_en && ccnt == 0) n++;
      if (n < 2) begin
        @(posedge clk); #1;
      end
    end
    chk("midrun reached 2nd issue", n, 2);
    chk("midrun issued before rst", int'(issued_cnt), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun rst busy", int'(busy), 0);
    chk("midrun rst done", int'(done), 0);
    chk("midrun rst error", int'(error), 0);
    chk("midrun rst imem_en", int'(imem_en), 0);
    chk("midrun rst ctrl_en", int'(ctrl_en), 0);
    chk("midrun rst issued_cnt", int'(issued_cnt), 0);
    chk("midrun rst imem_addr", int'(imem_addr), 0);
    chk("midrun rst ctrl_inst", int'(ctrl_inst), 0);

`ifdef SEQ_WATCHDOG_EN
    // Controller never answers: 64 ISSUE cycles (t+3..t+66), RELEASE t+67, DONE t+68
    begin
      int wd_done;
      wd_done = -1;
      hold = 1'b1;
      @(posedge clk); #1;
      base_addr = 10'd0; inst_count = 10'd3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= 200; k++) begin
        if (done) begin
          wd_done = k;
          chk("wd error at done", int'(error), 1);
          break;
        end
        @(posedge clk); #1;
      end
      chk("wd done_cycle", wd_done, 68);
      chk("wd issued_cnt", int'(issued_cnt), 0);
      hold = 1'b0;
      @(posedge clk); #1;
      chk("wd error sticky", int'(error), 1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
